alu_exception_unit: RTL
=======================

Name: alu_exception_unit

Overview:
- Consumes the ALU's 8-bit status word in the EX stage; it is the receiving end of the ALU status interface.
- Resolves beq/bne from the zero flag.
- Detects arithmetic-overflow and address-error exceptions, then latches EPC, Cause and BadVAddr.
- Sequences a pipeline flush and a redirect to the exception vector, and handles ERET return.

Parameters:
- EXC_VECTOR, 32'h8000_0180, redirect target on exception.
- RESET_EPC, 32'h0000_0000, EPC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ALU_status  in  8  [7] zero, [6] result exceeds 32-bit signed range, [5] signed overflow, [4] negative, [3] misaligned word address (low 2 bits nonzero); [2:0] unused.
- ALU_control  in  4  ALU operation of the EX instruction (0010 add, 0110 sub).
- ALU_result  in  32  ALU result, used as the faulting address.
- ex_valid  in  1  EX stage holds a real instruction.
- pc_in  in  32  PC of the EX instruction.
- ovf_trap_en  in  1  1 = add/sub trapping, 0 = addu/subu.
- mem_access  in  1  EX instruction is a word load/store.
- mem_write  in  1  store when 1.
- branch_type  in  2  00 none, 01 beq, 10 bne, 11 reserved (treated as none).
- eret  in  1  ERET in EX.
- branch_taken  out  1  branch resolves taken.
- flush  out  1  squash IF/ID/EX.
- pc_redirect  out  1  load redirect_pc into PC.
- redirect_pc  out  32  redirect target.
- epc  out  32  exception PC.
- cause  out  32  [6:2] ExcCode; all other bits 0.
- badvaddr  out  32  faulting address.
- exl  out  1  exception level.

Behaviour:
- Reset (async, rst=1): state=IDLE; epc=RESET_EPC; cause=0; badvaddr=0; exl=0; flush=0; pc_redirect=0; redirect_pc=0; branch_taken=0.

Detection (combinational, evaluated only in IDLE with ex_valid=1), in priority order:
1. mem_access & ALU_status[3]: ExcCode 5 (AdES) if mem_write, else 4 (AdEL).
2. ovf_trap_en & ALU_status[5] & ALU_control∈{0010,0110}: ExcCode 12 (Ov).
- Only one ExcCode is recorded per event.

FSM states: IDLE, FLUSH, VECTOR.
- IDLE, exception detected, on the clock edge:
  - cause[6:2]←code; badvaddr←ALU_result for address errors, unchanged for Ov.
  - If exl=0: epc←pc_in. If exl=1: epc is held.
  - exl←1; go to FLUSH.
- FLUSH: flush=1 for exactly one cycle; go to VECTOR.
- VECTOR: pc_redirect=1, redirect_pc=EXC_VECTOR for one cycle; flush=1 also held; go to IDLE.
- Exception-to-redirect latency is 2 cycles after the detect edge.
- Inputs arriving in FLUSH or VECTOR are ignored; those instructions are squashed.
- IDLE, eret & ex_valid, no exception: on the edge exl←0; the next cycle drives pc_redirect=1, redirect_pc=epc and flush=1 for one cycle. State stays IDLE, with a registered one-cycle ERET pulse.
- Exception and eret in the same cycle: exception wins; eret is dropped.

Branch resolution:
- branch_taken = ex_valid & state==IDLE & no exception & ((branch_type==01 & ALU_status[7]) | (branch_type==10 & ~ALU_status[7])). Combinational.
- An exception suppresses branch_taken.

Other rules:
- Reset asserted mid-sequence aborts to IDLE immediately; no redirect is issued.
- ex_valid=0: no detection, no branch, eret ignored.

Optional Feature:
- Macro ALU_EXC_COUNTER_EN.
- Defined: adds output exc_count[31:0], a saturating count of exceptions taken (each IDLE→FLUSH transition). It resets to 0, holds at 32'hFFFF_FFFF, and does not wrap.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_exc_pkg holds:
  - status bit indices: ST_ZERO=7, ST_WIDE=6, ST_OVF=5, ST_NEG=4, ST_MISAL=3;
  - ExcCode constants: EXC_ADEL=4, EXC_ADES=5, EXC_OV=12;
  - ALU_control encodings ALU_ADD/ALU_SUB;
  - the FSM state typedef.
- One sub-module, alu_exc_detect: combinational priority encoder producing exc_valid and exc_code from the status and control inputs.

Test Plan:
- Reset mid-FLUSH (rst pulsed during the state): all outputs return to reset values asynchronously, with no pc_redirect afterwards.
- Trapping add overflow: ALU_control=0010, ovf_trap_en=1, ALU_status=8'h20, pc_in=32'h0040_0010 → next edge epc=32'h0040_0010, cause=32'h30, exl=1; flush one cycle later; then pc_redirect=1, redirect_pc=32'h8000_0180.
- Misaligned store: mem_access=1, mem_write=1, ALU_result=32'h1000_0002, ALU_status=8'h08 → cause=32'h14, badvaddr=32'h1000_0002. The same input with ovf_trap_en=1 and status 8'h28 still gives cause=32'h14 (address error has priority).
- Branches: beq with status 8'h80 → branch_taken=1; bne with status 8'h80 → 0; beq with status 8'h80 plus an Ov condition → 0.
- Nested exception with exl=1: epc is held at its first value, cause is updated, and the redirect still occurs. A following eret → exl=0 and redirect_pc=epc.
- eret and overflow in the same cycle: exception path taken, exl stays 1, and redirect_pc=EXC_VECTOR.

Source files
------------

// File: rtl/alu_exception_unit_pkg.sv
// Shared constants and types for the ALU exception unit: status bit indices,
// ExcCode values, ALU opcodes and the sequencing FSM state type.
package alu_exc_pkg;

    localparam int ST_ZERO  = 7;
    localparam int ST_WIDE  = 6;
    localparam int ST_OVF   = 5;
    localparam int ST_NEG   = 4;
    localparam int ST_MISAL = 3;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_VECTOR = 2'd2
    } exc_state_e;

    // Cause register layout: ExcCode lives in bits [6:2], everything else zero.
    function automatic logic [31:0] make_cause(input logic [4:0] code);
        return {25'b0, code, 2'b00};
    endfunction

endpackage

// File: rtl/alu_exception_unit_if.sv
// ALU status bundle from the EX-stage ALU; the exception unit is the slave end.
interface alu_exception_unit_if;
    logic [7:0]  ALU_status;
    logic [3:0]  ALU_control;
    logic [31:0] ALU_result;

    modport master (output ALU_status, output ALU_control, output ALU_result);
    modport slave  (input  ALU_status, input  ALU_control, input  ALU_result);
endinterface

// File: rtl/alu_exception_unit_detect.sv
// Combinational exception priority encoder: address error beats trapping overflow,
// and exactly one ExcCode is reported per instruction.
module alu_exc_detect
    import alu_exc_pkg::*;
(
    input  logic [7:0] alu_status,
    input  logic [3:0] alu_control,
    input  logic       ovf_trap_en,
    input  logic       mem_access,
    input  logic       mem_write,
    output logic       exc_valid,
    output logic [4:0] exc_code,
    output logic       exc_addr_err
);

    wire unused_status = ^{alu_status[ST_ZERO], alu_status[ST_WIDE],
                           alu_status[ST_NEG], alu_status[2:0]};

    always_comb begin
        exc_valid    = 1'b0;
        exc_code     = '0;
        exc_addr_err = 1'b0;
        if (mem_access && alu_status[ST_MISAL]) begin
            exc_valid    = 1'b1;
            exc_addr_err = 1'b1;
            exc_code     = mem_write ? EXC_ADES : EXC_ADEL;
        end else if (ovf_trap_en && alu_status[ST_OVF] &&
                     (alu_control == ALU_ADD || alu_control == ALU_SUB)) begin
            exc_valid = 1'b1;
            exc_code  = EXC_OV;
        end
    end

endmodule

// File: rtl/alu_exception_unit.sv
// EX-stage exception unit: branch resolution, EPC/Cause/BadVAddr capture, flush and
// vector redirect sequencing, ERET return. ALU_EXC_COUNTER_EN adds exc_count.
module alu_exception_unit
    import alu_exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter logic [31:0] RESET_EPC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_exception_unit_if.slave  alu_if,
    input  logic                 ex_valid,
    input  logic [31:0]          pc_in,
    input  logic                 ovf_trap_en,
    input  logic                 mem_access,
    input  logic                 mem_write,
    input  logic [1:0]           branch_type,
    input  logic                 eret,
    output logic                 branch_taken,
    output logic                 flush,
    output logic                 pc_redirect,
    output logic [31:0]          redirect_pc,
    output logic [31:0]          epc,
    output logic [31:0]          cause,
    output logic [31:0]          badvaddr,
`ifdef ALU_EXC_COUNTER_EN
    output logic [31:0]          exc_count,
`endif
    output logic                 exl
);

    exc_state_e  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        exl_q, exl_d;
    logic        eret_pulse_q, eret_pulse_d;

    logic        det_valid;
    logic [4:0]  det_code;
    logic        det_addr_err;
    logic        idle_valid;
    logic        take_exc;
    logic        take_eret;

    alu_exc_detect u_detect (
        .alu_status   (alu_if.ALU_status),
        .alu_control  (alu_if.ALU_control),
        .ovf_trap_en  (ovf_trap_en),
        .mem_access   (mem_access),
        .mem_write    (mem_write),
        .exc_valid    (det_valid),
        .exc_code     (det_code),
        .exc_addr_err (det_addr_err)
    );

    // Anything seen outside IDLE is already being squashed, so it never counts.
    assign idle_valid = ex_valid && (state_q == S_IDLE);
    assign take_exc   = idle_valid && det_valid;
    assign take_eret  = idle_valid && eret && !det_valid;

    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        code_d       = code_q;
        badvaddr_d   = badvaddr_q;
        exl_d        = exl_q;
        eret_pulse_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take_exc) begin
                    code_d  = det_code;
                    exl_d   = 1'b1;
                    state_d = S_FLUSH;
                    if (det_addr_err) badvaddr_d = alu_if.ALU_result;
                    // A nested exception keeps the original return address.
                    if (!exl_q) epc_d = pc_in;
                end else if (take_eret) begin
                    exl_d        = 1'b0;
                    eret_pulse_d = 1'b1;
                end
            end
            S_FLUSH:  state_d = S_VECTOR;
            S_VECTOR: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flush        = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = '0;
        branch_taken = 1'b0;
        if (state_q == S_VECTOR) begin
            flush       = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = EXC_VECTOR;
        end else if (state_q == S_FLUSH) begin
            flush = 1'b1;
        end else if (eret_pulse_q) begin
            flush       = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = epc_q;
        end
        if (idle_valid && !det_valid) begin
            branch_taken = (branch_type == 2'b01 &&  alu_if.ALU_status[ST_ZERO]) ||
                           (branch_type == 2'b10 && !alu_if.ALU_status[ST_ZERO]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            epc_q        <= RESET_EPC;
            code_q       <= '0;
            badvaddr_q   <= '0;
            exl_q        <= 1'b0;
            eret_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            code_q       <= code_d;
            badvaddr_q   <= badvaddr_d;
            exl_q        <= exl_d;
            eret_pulse_q <= eret_pulse_d;
        end
    end

    assign epc      = epc_q;
    assign cause    = make_cause(code_q);
    assign badvaddr = badvaddr_q;
    assign exl      = exl_q;

`ifdef ALU_EXC_COUNTER_EN
    logic [31:0] exc_count_q, exc_count_d;

    always_comb begin
        exc_count_d = exc_count_q;
        if (take_exc && exc_count_q != 32'hFFFF_FFFF) exc_count_d = exc_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) exc_count_q <= '0;
        else     exc_count_q <= exc_count_d;
    end

    assign exc_count = exc_count_q;
`endif

endmodule
